// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encodings, load constants and parameter defaults
// for the pedestrian preemption controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_PREEMPT,
        ST_YIELD,
        ST_WALK
    } state_e;

    localparam logic [15:0] SETCNT_INIT    = 16'd120;
    localparam logic [15:0] SETCNT_PREEMPT = 16'd5;
    localparam logic [15:0] SETCNT_RUN     = 16'd0;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int MIN_GREEN_DEF       = 10;

    // The light controller only loads SETCOUNTER while EN is low.
    function automatic logic state_en(input state_e s);
        return !(s == ST_INIT || s == ST_PREEMPT);
    endfunction

    function automatic logic [15:0] state_setcnt(input state_e s);
        return (s == ST_INIT) ? SETCNT_INIT : (s == ST_PREEMPT) ? SETCNT_PREEMPT : SETCNT_RUN;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchronizer plus debounce counter; emits one
// single-cycle press pulse per qualified high level of the raw button.
module button_debouncer
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;

    // Counter parks at DEBOUNCE_CYCLES so a held button fires only once.
    always_comb begin
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q) begin
            press_d = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
            cnt_d   = (cnt_q == CW'(DEBOUNCE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/ped_preempt_ctrl.sv
// ped_preempt_ctrl: latches pedestrian requests and serves them either on the
// next natural red edge or by preempting a sufficiently long green.
module ped_preempt_ctrl
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int MIN_GREEN       = MIN_GREEN_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BUTTON,
    input  logic        RedLight,
    input  logic        YellowLight,
    input  logic        GreenLight,
    output logic        EN,
    output logic [15:0] SETCOUNTER,
    output logic        WalkLight,
    output logic        Pending
);

    state_e      state_q;
    state_e      state_d;
    logic        pending_q;
    logic        pending_d;
    logic [15:0] green_cnt_q;
    logic [15:0] green_cnt_d;
    logic        red_prev_q;
    logic        en_q;
    logic        en_d;
    logic [15:0] setcnt_q;
    logic [15:0] setcnt_d;
    logic        walk_q;
    logic        walk_d;
    logic        press;
    logic        red_edge;
    logic        green_ok;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk   (CLK),
        .rst   (RST),
        .button(BUTTON),
        .press (press)
    );

    assign red_edge = RedLight && !red_prev_q;
    // Never preempt a green the controller is already leaving.
    assign green_ok = GreenLight && !YellowLight && (green_cnt_q >= 16'(MIN_GREEN));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:    state_d = ST_IDLE;
            ST_IDLE:    state_d = pending_q ? ST_WAIT : ST_IDLE;
            ST_WAIT:    state_d = red_edge ? ST_WALK : green_ok ? ST_PREEMPT : ST_WAIT;
            ST_PREEMPT: state_d = ST_YIELD;
            ST_YIELD:   state_d = RedLight ? ST_WALK : ST_YIELD;
            ST_WALK:    state_d = RedLight ? ST_WALK : ST_IDLE;
            default:    state_d = ST_INIT;
        endcase
        pending_d   = (state_d == ST_WALK && state_q != ST_WALK) ? 1'b0 : (pending_q || press);
        green_cnt_d = !GreenLight ? 16'd0 : (&green_cnt_q) ? green_cnt_q : green_cnt_q + 16'd1;
        en_d        = state_en(state_d);
        setcnt_d    = state_setcnt(state_d);
        walk_d      = state_d == ST_WALK;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_INIT;
            pending_q   <= 1'b0;
            green_cnt_q <= 16'd0;
            red_prev_q  <= 1'b0;
            en_q        <= 1'b0;
            setcnt_q    <= SETCNT_INIT;
            walk_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            green_cnt_q <= green_cnt_d;
            red_prev_q  <= RedLight;
            en_q        <= en_d;
            setcnt_q    <= setcnt_d;
            walk_q      <= walk_d;
        end
    end

    assign EN         = en_q;
    assign SETCOUNTER = setcnt_q;
    assign WalkLight  = walk_q;
    assign Pending    = pending_q;

endmodule

// File: tb/tb_ped_preempt_ctrl.sv
// tb_ped_preempt_ctrl: directed-vector bench; the bench plays the downstream
// light controller by driving the light inputs by hand.
module tb_ped_preempt_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        BUTTON = 1'b0;
    logic        RedLight = 1'b1;
    logic        YellowLight = 1'b0;
    logic        GreenLight = 1'b0;
    logic        EN;
    logic [15:0] SETCOUNTER;
    logic        WalkLight;
    logic        Pending;

    int checks = 0;
    int errors = 0;

    ped_preempt_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .BUTTON     (BUTTON),
        .RedLight   (RedLight),
        .YellowLight(YellowLight),
        .GreenLight (GreenLight),
        .EN         (EN),
        .SETCOUNTER (SETCOUNTER),
        .WalkLight  (WalkLight),
        .Pending    (Pending)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic lights(input logic r, input logic y, input logic g);
        RedLight    = r;
        YellowLight = y;
        GreenLight  = g;
    endtask

    initial begin
        logic prev;
        int   rises;
        bit   found;

        tick(3);
        chk("rst_en", 32'(EN), 0);
        chk("rst_setcnt", 32'(SETCOUNTER), 120);
        chk("rst_walk", 32'(WalkLight), 0);
        chk("rst_pend", 32'(Pending), 0);
        RST = 1'b0;
        #1;
        chk("init_en", 32'(EN), 0);
        chk("init_setcnt", 32'(SETCOUNTER), 120);
        tick(1);
        chk("idle_en", 32'(EN), 1);
        chk("idle_setcnt", 32'(SETCOUNTER), 0);

        BUTTON = 1'b1;
        tick(3);
        BUTTON = 1'b0;
        tick(8);
        chk("short_press", 32'(Pending), 0);

        BUTTON = 1'b1;
        rises = 0;
        prev  = Pending;
        for (int i = 0; i < 14; i++) begin
            if (i == 6) BUTTON = 1'b0;
            tick(1);
            if (Pending && !prev) rises++;
            prev = Pending;
        end
        chk("long_press_rises", 32'(rises), 1);
        chk("long_press_pend", 32'(Pending), 1);
        chk("wait_red_en", 32'(EN), 1);

        lights(1'b0, 1'b0, 1'b1);
        tick(10);
        chk("min_green_hold", 32'(EN), 1);
        tick(1);
        chk("preempt_en", 32'(EN), 0);
        chk("preempt_setcnt", 32'(SETCOUNTER), 5);
        tick(1);
        chk("yield_en", 32'(EN), 1);
        chk("yield_setcnt", 32'(SETCOUNTER), 0);
        chk("yield_pend", 32'(Pending), 1);
        lights(1'b0, 1'b1, 1'b0);
        tick(3);
        chk("yellow_walk", 32'(WalkLight), 0);
        chk("yellow_en", 32'(EN), 1);
        lights(1'b1, 1'b0, 1'b0);
        tick(1);
        chk("walk1_walk", 32'(WalkLight), 1);
        chk("walk1_pend", 32'(Pending), 0);

        BUTTON = 1'b1;
        tick(6);
        BUTTON = 1'b0;
        tick(2);
        chk("walk_press_pend", 32'(Pending), 1);
        chk("walk_press_walk", 32'(WalkLight), 1);
        lights(1'b0, 1'b0, 1'b1);
        tick(1);
        chk("red_end_walk", 32'(WalkLight), 0);
        chk("red_end_en", 32'(EN), 1);
        tick(9);
        chk("second_hold", 32'(EN), 1);
        tick(1);
        chk("second_preempt_en", 32'(EN), 0);
        chk("second_preempt_sc", 32'(SETCOUNTER), 5);
        lights(1'b1, 1'b0, 1'b0);
        tick(2);
        chk("walk2_walk", 32'(WalkLight), 1);
        chk("walk2_pend", 32'(Pending), 0);

        lights(1'b0, 1'b0, 1'b1);
        BUTTON = 1'b1;
        tick(1);
        chk("nat_idle_walk", 32'(WalkLight), 0);
        tick(5);
        BUTTON = 1'b0;
        tick(2);
        chk("nat_pend", 32'(Pending), 1);
        lights(1'b0, 1'b1, 1'b0);
        tick(4);
        chk("nat_no_preempt", 32'(EN), 1);
        chk("nat_wait_walk", 32'(WalkLight), 0);
        lights(1'b1, 1'b0, 1'b0);
        tick(1);
        chk("nat_walk", 32'(WalkLight), 1);
        chk("nat_pend_clr", 32'(Pending), 0);
        chk("nat_en", 32'(EN), 1);

        lights(1'b0, 1'b0, 1'b1);
        BUTTON = 1'b1;
        tick(6);
        BUTTON = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1);
            found = !EN;
        end
        chk("rst_pre_reached", 32'(found), 1);
        chk("rst_pre_setcnt", 32'(SETCOUNTER), 5);
        RST = 1'b1;
        #1;
        chk("async_en", 32'(EN), 0);
        chk("async_setcnt", 32'(SETCOUNTER), 120);
        chk("async_walk", 32'(WalkLight), 0);
        chk("async_pend", 32'(Pending), 0);
        tick(1);
        RST = 1'b0;
        tick(1);
        chk("post_rst_en", 32'(EN), 1);
        tick(5);
        chk("post_rst_pend", 32'(Pending), 0);
        chk("post_rst_setcnt", 32'(SETCOUNTER), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ped_preempt_ctrl.md
PED_PREEMPT_CTRL -- requirements
Module: ped_preempt_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized high samples that qualify a press.
REQ-002 Parameter MIN_GREEN, default 10: minimum green cycles before preemption is allowed.
REQ-003 CLK  input  1  single system clock; all logic on posedge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 BUTTON  input  1  raw pedestrian push-button, asynchronous to CLK.
REQ-006 RedLight, YellowLight, GreenLight  input  1 each  light state fed back from the downstream light controller.
REQ-007 EN  output  1  run enable to the light controller; 0 forces a load from SETCOUNTER.
REQ-008 SETCOUNTER  output  16  load value to the light controller.
REQ-009 WalkLight  output  1  pedestrian walk indication.
REQ-010 Pending  output  1  a pedestrian request is latched and not yet served.

Function
REQ-011 BUTTON SHALL pass a 2-flop synchronizer, then a debounce counter; a press is qualified when the synchronized level has been 1 for DEBOUNCE_CYCLES consecutive cycles, one qualified press per high level, re-armed only after a 0 sample.
REQ-012 A qualified press SHALL set Pending on the next cycle; presses while Pending=1 are ignored; Pending SHALL clear on the cycle WALK is entered.
REQ-013 A press qualified while in WALK SHALL set Pending and be served in a later cycle.
REQ-014 green_cnt (16 bit) SHALL count consecutive cycles with GreenLight=1, saturate at 16'hFFFF, and clear on any cycle with GreenLight=0.
REQ-015 The FSM SHALL have states INIT, IDLE, WAIT, PREEMPT, YIELD, WALK.
REQ-016 INIT: EN=0, SETCOUNTER=120; the FSM SHALL go to IDLE after one cycle.
REQ-017 IDLE: EN=1, SETCOUNTER=0; the FSM SHALL go to WAIT when Pending=1.
REQ-018 WAIT: EN=1; RedLight 0->1 edge -> WALK (natural service); otherwise GreenLight=1 and green_cnt>=MIN_GREEN -> PREEMPT; otherwise stay.
REQ-019 The red-edge condition SHALL take priority over the green condition in WAIT.
REQ-020 PREEMPT: EN=0, SETCOUNTER=5 for exactly one cycle, then YIELD (downstream enters yellow with counter 5).
REQ-021 YIELD: EN=1, SETCOUNTER=0; RedLight=1 -> WALK.
REQ-022 WALK: EN=1, WalkLight=1 while in state; RedLight=0 -> IDLE (WalkLight low the same cycle the state leaves).
REQ-023 WalkLight SHALL be 1 only in WALK; EN SHALL be 0 only in INIT and PREEMPT.
REQ-024 All outputs SHALL be registered; state output latency is one CLK from the transition condition.
REQ-025 A request arriving during yellow or red SHALL wait for the next red edge or qualifying green.

Reset
REQ-026 RST=1 SHALL asynchronously force state=INIT, EN=0, SETCOUNTER=120, WalkLight=0, Pending=0, green_cnt=0, debounce counter=0, synchronizer flops=0.
REQ-027 Reset asserted mid-WALK or mid-PREEMPT SHALL abort immediately with no pending request retained.

Structure
REQ-028 A shared package traffic_pkg SHALL hold the state encodings, SETCOUNTER constants (120 init, 5 preempt) and parameter defaults.
REQ-029 Synchronizer and debounce SHALL be one sub-module, button_debouncer, emitting a single-cycle press pulse.

Verification
REQ-030 Reset release -> EN=0, SETCOUNTER=120 for one cycle, then EN=1; with the light controller attached, RedLight=1.
REQ-031 BUTTON high for 3 cycles (DEBOUNCE_CYCLES=4) -> Pending stays 0; high for 6 cycles -> Pending=1 exactly once.
REQ-032 Pending during green with green_cnt=12 -> one cycle EN=0 and SETCOUNTER=5, then YellowLight=1, then RedLight=1 and WalkLight=1.
REQ-033 Press at green_cnt=3 with green ending naturally -> no PREEMPT; WALK entered on the red edge.
REQ-034 Press during WALK -> Pending=1, WalkLight drops at red end, IDLE then WAIT, served on the next qualifying green.
REQ-035 RST pulsed in PREEMPT -> outputs at reset values within the same cycle; Pending=0 after release.
